key_repeat_ctrl: RTL and testbench
==================================

# key_repeat_ctrl

Converts the raw USB keyboard keycode into single-frame move command pulses (left, right, soft drop, rotate, hard drop), with a stability filter, delayed auto-shift (DAS) and auto-repeat. Sits directly upstream of the game-logic block. That block consumes one pulse per intended move instead of re-sampling a held key on its own timers. The whole block runs in the frame_clk domain.

## Interface
- KEY_LEFT, 8'h04, keycode for move left (A)
- KEY_RIGHT, 8'h07, keycode for move right (D)
- KEY_DOWN, 8'h16, keycode for soft drop (S)
- KEY_ROT, 8'h1A, keycode for rotate (W)
- KEY_DROP, 8'h2C, keycode for hard drop (space)
- DAS_FRAMES, 10, frames from first left/right pulse to first repeat; legal range 1..255
- ARR_FRAMES, 3, frames between left/right repeats after DAS; legal range 1..255
- SOFT_ARR_FRAMES, 2, frames between soft-drop repeats, with no DAS; legal range 1..255

Ports:
- frame_clk  in  1  frame clock; all state updates on the rising edge
- Reset  in  1  reset, asynchronous, active-high
- keycode  in  8  raw keycode; may change at any time relative to frame_clk
- enable  in  1  0 = suppress all pulses and force IDLE (piece spawning / game over)
- move_left  out  1  one-frame pulse
- move_right  out  1  one-frame pulse
- move_down  out  1  one-frame pulse
- rotate  out  1  one-frame pulse
- hard_drop  out  1  one-frame pulse
- key_active  out  1  high while a recognized key is stable and enabled (debug/LED)

## Operation
- Filter: keycode is registered into kq on every edge. When keycode == kq at an edge, kstable <= kq. kstable changes only after two consecutive equal samples.
- Key class is decoded from kstable: LEFT, RIGHT, DOWN, ROT, DROP, or NONE. Any other code is NONE.
- FSM states:
  - IDLE: no key.
  - FIRST: emit the first pulse.
  - DAS: count to the first repeat.
  - REPEAT: periodic pulses.
  - HOLD: non-repeating key held.
- Transitions:
  - IDLE -> FIRST when the class becomes non-NONE and enable=1.
  - FIRST pulses the class's output for one cycle, then:
    - LEFT/RIGHT -> DAS with counter = DAS_FRAMES-1.
    - DOWN -> REPEAT with counter = SOFT_ARR_FRAMES-1.
    - ROT/DROP -> HOLD.
  - DAS: decrement; at 0 -> REPEAT and pulse, counter = ARR_FRAMES-1.
  - REPEAT: decrement; at 0 pulse and reload with ARR_FRAMES-1 (SOFT_ARR_FRAMES-1 for DOWN).
  - HOLD: no pulses until the class changes.
- Class change (including to another non-NONE key) from any state:
  - Go to FIRST-equivalent behaviour: the new key's first pulse happens on the same edge the change is seen.
  - The counter is reloaded for the new class.
- Class NONE from any state -> IDLE.
- Same key re-press: a new first pulse requires kstable to pass through a different value for at least one edge.
- enable=0: all pulses are 0, the FSM goes to IDLE, and kq/kstable keep filtering.
  - When enable returns to 1 with a key still held, the sequence restarts from FIRST.
- At most one pulse output is high in any cycle.
- Counter is 8 bits, unsigned. Reload values are computed at parameter width and never wrap.

## Timing
- Reset values: kq=0, kstable=0, FSM=IDLE, counter=0, all pulse outputs 0, key_active=0.
- Reset mid-hold: outputs drop to 0 asynchronously. After release, the held key needs the full 2-edge filter again before its first pulse.
- Latency: let E1 be the first edge after keycode settles.
  - E1 captures kq.
  - E2 updates kstable and registers the first pulse, which is high E2..E3.
- Left/right pulse edges: E2, E2+DAS_FRAMES, then every ARR_FRAMES.
- Down pulse edges: E2, then every SOFT_ARR_FRAMES.
- Glitch: a keycode value present at only one edge never reaches kstable and produces no pulse.
- All outputs are registered. There is no combinational path from keycode to any output.

## Structure
- Shared package tetris_pkg holds:
  - the keycode constants;
  - key_class_t enum (NONE, LEFT, RIGHT, DOWN, ROT, DROP);
  - ctrl_state_t enum.
- One sub-module, keycode_filter: kq/kstable registers plus the class decode. It outputs a key_class_t and a class_changed strobe.
- The FSM, counter and pulse registers stay in key_repeat_ctrl.

## Test plan
- Reset, then keycode=8'h04 held 30 frames (defaults) -> move_left pulses at E2, E2+10, E2+13, E2+16, …, E2+28; no other outputs.
- keycode=8'h16 held 8 frames -> move_down at E2, E2+2, E2+4, E2+6; released -> no further pulses.
- keycode=8'h1A held 20 frames, released, re-pressed -> exactly one rotate per press. Same for 8'h2C/hard_drop.
- keycode=8'h07 for one frame only (glitch), and keycode=8'h55 held -> no pulses at all.
- Hold 8'h04 for 5 frames, then switch directly to 8'h07 -> move_right on the 2nd edge after the switch; DAS restarts, next move_right 10 frames later.
- Hold 8'h04; drop enable for 4 frames mid-DAS, then assert Reset mid-REPEAT -> no pulses while enable=0; first pulse again right after enable=1; all outputs 0 immediately on Reset.

Source files
------------

// File: rtl/key_repeat_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// tetris_pkg : keycodes, key classes and controller states for key_repeat_ctrl
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tetris_pkg;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_ROT   = 8'h1A;
  localparam logic [7:0] KEY_DROP  = 8'h2C;

  typedef enum logic [2:0] {
    KC_NONE  = 3'd0,
    KC_LEFT  = 3'd1,
    KC_RIGHT = 3'd2,
    KC_DOWN  = 3'd3,
    KC_ROT   = 3'd4,
    KC_DROP  = 3'd5
  } key_class_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRST  = 3'd1,
    ST_DAS    = 3'd2,
    ST_REPEAT = 3'd3,
    ST_HOLD   = 3'd4
  } ctrl_state_t;

  function automatic key_class_t decode_key(input logic [7:0] code);
    case (code)
      KEY_LEFT:  return KC_LEFT;
      KEY_RIGHT: return KC_RIGHT;
      KEY_DOWN:  return KC_DOWN;
      KEY_ROT:   return KC_ROT;
      KEY_DROP:  return KC_DROP;
      default:   return KC_NONE;
    endcase
  endfunction

  // Bit order: {hard_drop, rotate, move_down, move_right, move_left}
  function automatic logic [4:0] class_pulse(input key_class_t kc);
    logic [4:0] p;
    p = 5'b0;
    case (kc)
      KC_LEFT:  p[0] = 1'b1;
      KC_RIGHT: p[1] = 1'b1;
      KC_DOWN:  p[2] = 1'b1;
      KC_ROT:   p[3] = 1'b1;
      KC_DROP:  p[4] = 1'b1;
      default:  p = 5'b0;
    endcase
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_repeat_ctrl_if.sv
// ----------------------------------------------------------------------------
// key_repeat_ctrl_if : keyboard-side inputs and move-pulse outputs
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface key_repeat_ctrl_if;
  logic [7:0] keycode;
  logic       enable;
  logic       move_left;
  logic       move_right;
  logic       move_down;
  logic       rotate;
  logic       hard_drop;
  logic       key_active;

  modport master (
    output keycode, enable,
    input  move_left, move_right, move_down, rotate, hard_drop, key_active
  );

  modport slave (
    input  keycode, enable,
    output move_left, move_right, move_down, rotate, hard_drop, key_active
  );
endinterface

`default_nettype wire

// File: rtl/key_repeat_ctrl_keycode_filter.sv
// ----------------------------------------------------------------------------
// keycode_filter : two-sample stability filter on the raw keycode plus decode
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keycode_filter
  import tetris_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output key_class_t key_class,
  output logic       class_changed
);

  logic [7:0] kq_q, kq_d;
  logic [7:0] kstable_q, kstable_d;

  always_comb begin
    kq_d      = keycode;
    kstable_d = (keycode == kq_q) ? kq_q : kstable_q;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      kq_q      <= 8'h00;
      kstable_q <= 8'h00;
    end else begin
      kq_q      <= kq_d;
      kstable_q <= kstable_d;
    end
  end

  // Class of the value kstable takes at this edge, so the FSM reacts on that same edge
  assign key_class     = decode_key(kstable_d);
  assign class_changed = (key_class != decode_key(kstable_q));

endmodule

`default_nettype wire

// File: rtl/key_repeat_ctrl.sv
// ----------------------------------------------------------------------------
// key_repeat_ctrl : filtered keycode -> one-frame move pulses with DAS/repeat
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module key_repeat_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_FRAMES      = 10,
  parameter int unsigned ARR_FRAMES      = 3,
  parameter int unsigned SOFT_ARR_FRAMES = 2
) (
  input  logic              frame_clk,
  input  logic              Reset,
  key_repeat_ctrl_if.slave  bus
);

  localparam logic [7:0] DAS_RELOAD  = 8'(DAS_FRAMES - 1);
  localparam logic [7:0] ARR_RELOAD  = 8'(ARR_FRAMES - 1);
  localparam logic [7:0] SOFT_RELOAD = 8'(SOFT_ARR_FRAMES - 1);

  key_class_t  key_class;
  logic        class_changed;

  ctrl_state_t state_q, state_d, eff_state;
  logic [7:0]  count_q, count_d;
  logic [4:0]  pulse_q, pulse_d;
  logic        active_q, active_d;

  keycode_filter u_filter (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (bus.keycode),
    .key_class     (key_class),
    .class_changed (class_changed)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pulse_d   = 5'b0;
    active_d  = 1'b0;
    eff_state = state_q;
    if (!bus.enable || key_class == KC_NONE) begin
      state_d = ST_IDLE;
      count_d = 8'h00;
    end else begin
      active_d = 1'b1;
      if (state_q == ST_IDLE || class_changed) begin
        pulse_d = class_pulse(key_class);
        state_d = ST_FIRST;
        case (key_class)
          KC_LEFT, KC_RIGHT: count_d = DAS_RELOAD;
          KC_DOWN:           count_d = SOFT_RELOAD;
          default:           count_d = 8'h00;
        endcase
      end else begin
        // FIRST only marks the pulse cycle; the counter already runs as its successor
        if (state_q == ST_FIRST) begin
          case (key_class)
            KC_LEFT, KC_RIGHT: eff_state = ST_DAS;
            KC_DOWN:           eff_state = ST_REPEAT;
            default:           eff_state = ST_HOLD;
          endcase
        end
        case (eff_state)
          ST_DAS, ST_REPEAT: begin
            if (count_q == 8'h00) begin
              pulse_d = class_pulse(key_class);
              state_d = ST_REPEAT;
              count_d = (key_class == KC_DOWN) ? SOFT_RELOAD : ARR_RELOAD;
            end else begin
              state_d = eff_state;
              count_d = count_q - 8'd1;
            end
          end
          default: state_d = ST_HOLD;
        endcase
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      count_q  <= 8'h00;
      pulse_q  <= 5'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pulse_q  <= pulse_d;
      active_q <= active_d;
    end
  end

  assign bus.move_left  = pulse_q[0];
  assign bus.move_right = pulse_q[1];
  assign bus.move_down  = pulse_q[2];
  assign bus.rotate     = pulse_q[3];
  assign bus.hard_drop  = pulse_q[4];
  assign bus.key_active = active_q;

endmodule

`default_nettype wire

// File: tb/tb_key_repeat_ctrl.sv
// ----------------------------------------------------------------------------
// tb_key_repeat_ctrl : directed and random stimulus against a timeline model
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_key_repeat_ctrl;

  localparam int DAS  = 10;
  localparam int ARR  = 3;
  localparam int SOFT = 2;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;

  key_repeat_ctrl_if bus ();

  key_repeat_ctrl #(
    .DAS_FRAMES      (DAS),
    .ARR_FRAMES      (ARR),
    .SOFT_ARR_FRAMES (SOFT)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int errors = 0;

  // Expected {key_active, hard_drop, rotate, move_down, move_right, move_left}
  logic [5:0] exp_q[$];

  // Model state: filter samples, running class and frames since its first pulse
  logic [7:0] m_kq = 8'h00;
  logic [7:0] m_ks = 8'h00;
  int         m_prev_cls = 0;
  bit         m_run = 1'b0;
  int         m_t = 0;

  function automatic int cls_of(input logic [7:0] code);
    case (code)
      8'h04:   return 1;
      8'h07:   return 2;
      8'h16:   return 3;
      8'h1A:   return 4;
      8'h2C:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic bit pulse_due(input int c, input int t);
    case (c)
      1, 2:    return (t == 0) || (t == DAS) || (t > DAS && ((t - DAS) % ARR) == 0);
      3:       return (t % SOFT) == 0;
      default: return t == 0;
    endcase
  endfunction

  function automatic logic [5:0] actual();
    return {bus.key_active, bus.hard_drop, bus.rotate, bus.move_down,
            bus.move_right, bus.move_left};
  endfunction

  // Called at a negedge: applies inputs and queues what the next posedge must produce
  task automatic step(input logic [7:0] code, input logic en, input logic rst);
    logic [5:0] e;
    int         c;
    bus.keycode = code;
    bus.enable  = en;
    Reset       = rst;
    e = 6'b0;
    if (rst) begin
      m_kq = 8'h00; m_ks = 8'h00; m_prev_cls = 0; m_run = 1'b0; m_t = 0;
    end else begin
      if (code == m_kq) m_ks = m_kq;
      m_kq = code;
      c = cls_of(m_ks);
      if (!en || c == 0) begin
        m_run = 1'b0;
      end else if (!m_run || c != m_prev_cls) begin
        m_run = 1'b1;
        m_t   = 0;
      end else begin
        m_t++;
      end
      if (m_run) begin
        e[5] = 1'b1;
        if (pulse_due(c, m_t)) e[c-1] = 1'b1;
      end
      m_prev_cls = c;
    end
    exp_q.push_back(e);
    @(negedge frame_clk);
  endtask

  task automatic hold(input logic [7:0] code, input int n);
    for (int i = 0; i < n; i++) step(code, 1'b1, 1'b0);
  endtask

  always @(posedge frame_clk) begin
    logic [5:0] e;
    logic [5:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got %b expected %b", $time, a, e);
      end
      checks++;
      if ($countones(a[4:0]) > 1) begin
        errors++;
        $display("FAIL onehot @%0t: got %b expected at most one pulse", $time, a[4:0]);
      end
    end
  end

  initial begin
    logic [7:0] keys [7];
    keys = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'h55, 8'h00};
    bus.keycode = 8'h00;
    bus.enable  = 1'b0;
    @(negedge frame_clk);
    checks++;
    if (actual() !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected 000000", actual());
    end
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b1);

    hold(8'h04, 30); hold(8'h00, 3);
    hold(8'h16, 8);  hold(8'h00, 4);
    hold(8'h1A, 20); hold(8'h00, 3); hold(8'h1A, 20); hold(8'h00, 3);
    hold(8'h2C, 20); hold(8'h00, 3); hold(8'h2C, 20); hold(8'h00, 3);
    hold(8'h07, 1);  hold(8'h00, 3); hold(8'h55, 10); hold(8'h00, 2);
    hold(8'h04, 5);  hold(8'h07, 15); hold(8'h00, 2);

    // Enable drop mid-DAS, then async reset while a repeat pulse is high
    hold(8'h04, 6);
    for (int i = 0; i < 4; i++) step(8'h04, 1'b0, 1'b0);
    hold(8'h04, 14);
    Reset = 1'b1;
    #1;
    checks++;
    if (actual() !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 000000", actual());
    end
    step(8'h04, 1'b1, 1'b1);
    step(8'h04, 1'b1, 1'b1);
    hold(8'h04, 4); hold(8'h00, 2);

    for (int n = 0; n < 60; n++) begin
      logic [7:0] k;
      logic       en;
      int         len;
      k   = keys[$urandom_range(0, 6)];
      en  = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) step(k, en, 1'b0);
    end
    hold(8'h00, 2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
